// File: rtl/share_collector_pkg.sv
// Shared configuration for the share collector: FSM state encoding and default sizing.
package share_collector_pkg;

  localparam int unsigned DEF_N_SHARES   = 4;
  localparam int unsigned DEF_SETTLE_CYC = 8;
  localparam int unsigned DEF_CNT_W      = 16;

  // Settle counter must hold SETTLE_CYC-1 for SETTLE_CYC up to 255.
  localparam int unsigned SETTLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/share_collector_share_xor.sv
// Parameterised XOR reduction recombining the masked shares into the unmasked bit.
module share_xor #(
  parameter int unsigned N_SHARES = 4
) (
  input  logic [N_SHARES-1:0] shares_i,
  output logic                parity_o
);

  assign parity_o = ^shares_i;

endmodule

// File: rtl/share_collector.sv
// Runs one masked-gadget trial per start pulse: waits for the gadget to settle,
// recombines its shares, reports the result by handshake and keeps trial/error counts.
module share_collector
  import share_collector_pkg::*;
#(
  parameter int unsigned N_SHARES   = DEF_N_SHARES,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                VGND,
  input  logic                VPWR,
  input  logic [N_SHARES-1:0] shares,
  input  logic                start,
  input  logic                expected,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_bit,
  output logic                res_err,
  output logic [CNT_W-1:0]    n_trials,
  output logic [CNT_W-1:0]    n_errors,
  input  logic                clr
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                exp_q, exp_d;
  logic                bit_q, bit_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    trials_q, trials_d;
  logic [CNT_W-1:0]    errors_q, errors_d;
  logic                xor_bit;

  // Power pins only matter in gate-level netlists.
  logic unused_power;
  assign unused_power = VGND ^ VPWR;

  share_xor #(
    .N_SHARES(N_SHARES)
  ) u_share_xor (
    .shares_i(shares),
    .parity_o(xor_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      exp_q    <= 1'b0;
      bit_q    <= 1'b0;
      err_q    <= 1'b0;
      trials_q <= '0;
      errors_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      bit_q    <= bit_d;
      err_q    <= err_d;
      trials_q <= trials_d;
      errors_q <= errors_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    bit_d    = bit_q;
    err_d    = err_q;
    trials_d = trials_q;
    errors_d = errors_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d   = expected;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        bit_d   = xor_bit;
        err_d   = xor_bit ^ exp_q;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          if (trials_q != '1) trials_d = trials_q + 1'b1;
          if (err_q && (errors_q != '1)) errors_d = errors_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear overrides any same-cycle handshake increment.
    if (clr) begin
      trials_d = '0;
      errors_d = '0;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_REPORT);
  assign res_bit   = bit_q;
  assign res_err   = err_q;
  assign n_trials  = trials_q;
  assign n_errors  = errors_q;

endmodule

// File: tb/tb_share_collector.sv
// Self-checking bench for share_collector: scenario tasks against a parity/counter reference model.
module tb_share_collector;

  localparam int SC  = 8;
  localparam int SC4 = 3;

  logic clk = 1'b0;
  logic rst, vgnd, vpwr;
  logic [3:0] shares;
  logic start, expected, res_ready, clr;
  logic busy, res_valid, res_bit, res_err;
  logic [15:0] n_trials, n_errors;
  logic start4, expected4, res_ready4, clr4;
  logic busy4, res_valid4, res_bit4, res_err4;
  logic [3:0] n_trials4, n_errors4;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int m_trials  = 0;
  int m_errors  = 0;

  always #5 clk = ~clk;

  share_collector #(.N_SHARES(4), .SETTLE_CYC(SC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .VGND(vgnd), .VPWR(vpwr), .shares(shares),
    .start(start), .expected(expected), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_bit(res_bit), .res_err(res_err),
    .n_trials(n_trials), .n_errors(n_errors), .clr(clr)
  );

  share_collector #(.N_SHARES(4), .SETTLE_CYC(SC4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .VGND(vgnd), .VPWR(vpwr), .shares(shares),
    .start(start4), .expected(expected4), .busy(busy4), .res_valid(res_valid4),
    .res_ready(res_ready4), .res_bit(res_bit4), .res_err(res_err4),
    .n_trials(n_trials4), .n_errors(n_errors4), .clr(clr4)
  );

  function automatic logic ref_parity(input logic [3:0] s);
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) if (s[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  task automatic pulse_start(input logic [3:0] s, input logic e);
    shares   = s;
    expected = e;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Presents the true shares only in the cycle the sample edge should fall in.
  task automatic wait_valid(input logic [3:0] good, input logic [3:0] bad,
                            input int first, output int edges);
    edges  = first;
    shares = (edges == SC + 1) ? good : bad;
    while (res_valid !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
      shares = (edges == SC + 1) ? good : bad;
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({busy, res_valid, res_bit, res_err} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy, res_valid, res_bit, res_err});
    else pass_cnt++;
    total_cnt++;
    if (n_trials !== 16'd0 || n_errors !== 16'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", n_trials, n_errors);
    else pass_cnt++;
    total_cnt++;
    if ({busy4, res_valid4, n_trials4, n_errors4} !== 10'd0)
      $display("FAIL reset_dut4: got %b want 0", {busy4, res_valid4, n_trials4, n_errors4});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] g [2];
    int edges;
    logic rb, re;
    g[0] = 4'b0110;
    g[1] = 4'b0111;
    for (int t = 0; t < 2; t++) begin
      pulse_start(g[t] ^ 4'b0001, 1'b0);
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
      else pass_cnt++;
      wait_valid(g[t], g[t] ^ 4'b0001, 1, edges);
      rb = ref_parity(g[t]);
      re = rb;
      total_cnt++;
      if (edges != SC + 2) $display("FAIL basic_latency: got %0d want %0d", edges, SC + 2);
      else pass_cnt++;
      total_cnt++;
      if ({res_bit, res_err} !== {rb, re})
        $display("FAIL basic_result: got %b%b want %b%b", res_bit, res_err, rb, re);
      else pass_cnt++;
      handshake();
      m_trials++;
      m_errors += int'(re);
      total_cnt++;
      if (n_trials !== 16'(m_trials) || n_errors !== 16'(m_errors) || busy !== 1'b0)
        $display("FAIL basic_counters: got %0d/%0d busy %b want %0d/%0d busy 0",
                 n_trials, n_errors, busy, m_trials, m_errors);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0] g;
    logic e, rb, re;
    int edges;
    for (int t = 0; t < 10; t++) begin
      g = 4'($urandom);
      e = 1'($urandom);
      pulse_start(g ^ 4'b0100, e);
      wait_valid(g, g ^ 4'b0100, 1, edges);
      rb = ref_parity(g);
      re = rb ^ e;
      total_cnt++;
      if (edges != SC + 2 || res_bit !== rb || res_err !== re)
        $display("FAIL random_result: got lat %0d %b%b want lat %0d %b%b",
                 edges, res_bit, res_err, SC + 2, rb, re);
      else pass_cnt++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
      m_trials++;
      m_errors += int'(re);
      total_cnt++;
      if (n_trials !== 16'(m_trials) || n_errors !== 16'(m_errors))
        $display("FAIL random_counters: got %0d/%0d want %0d/%0d",
                 n_trials, n_errors, m_trials, m_errors);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    int edges;
    int bad;
    pulse_start(4'b1011, 1'b0);
    wait_valid(4'b1010, 4'b1011, 1, edges);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      shares = 4'($urandom);
      if ({res_valid, res_bit, res_err} !== 3'b100 ||
          n_trials !== 16'(m_trials) || n_errors !== 16'(m_errors)) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
    else pass_cnt++;
    handshake();
    m_trials++;
  endtask

  task automatic test_ignore_start();
    int edges;
    int extra;
    pulse_start(4'b0110, 1'b0);
    shares   = 4'b0110;
    expected = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    expected = 1'b0;
    wait_valid(4'b0111, 4'b0110, 2, edges);
    total_cnt++;
    if (edges != SC + 2 || res_bit !== 1'b1 || res_err !== 1'b1)
      $display("FAIL ignore_result: got lat %0d %b%b want lat %0d 11",
               edges, res_bit, res_err, SC + 2);
    else pass_cnt++;
    handshake();
    m_trials++;
    m_errors++;
    extra = 0;
    repeat (SC + 4) begin
      @(negedge clk);
      if (res_valid === 1'b1 || busy === 1'b1) extra++;
    end
    total_cnt++;
    if (extra != 0 || n_trials !== 16'(m_trials))
      $display("FAIL ignore_single: got %0d extra cycles trials %0d want 0 trials %0d",
               extra, n_trials, m_trials);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int edges;
    res_ready = 1'b1;
    pulse_start(4'b0001, 1'b0);
    wait_valid(4'b0001, 4'b0000, 1, edges);
    @(negedge clk);
    m_trials++;
    total_cnt++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || n_trials !== 16'(m_trials))
      $display("FAIL early_ready: got valid %b busy %b trials %0d want 0 0 %0d",
               res_valid, busy, n_trials, m_trials);
    else pass_cnt++;
    pulse_start(4'b0000, 1'b1);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy %b want 1", busy);
    else pass_cnt++;
    wait_valid(4'b0011, 4'b0010, 1, edges);
    total_cnt++;
    if (edges != SC + 2 || res_bit !== 1'b0 || res_err !== 1'b1)
      $display("FAIL b2b_result: got lat %0d %b%b want lat %0d 01", edges, res_bit, res_err, SC + 2);
    else pass_cnt++;
    @(negedge clk);
    res_ready = 1'b0;
    m_trials++;
    m_errors++;
  endtask

  task automatic test_clr_handshake();
    int edges;
    pulse_start(4'b1111, 1'b1);
    wait_valid(4'b1110, 4'b1111, 1, edges);
    res_ready = 1'b1;
    clr       = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    clr       = 1'b0;
    m_trials  = 0;
    m_errors  = 0;
    total_cnt++;
    if (n_trials !== 16'd0 || n_errors !== 16'd0 || res_valid !== 1'b0)
      $display("FAIL clr_wins: got %0d/%0d valid %b want 0/0 valid 0", n_trials, n_errors, res_valid);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int edges;
    pulse_start(4'b0111, 1'b0);
    wait_valid(4'b0111, 4'b0111, 1, edges);
    handshake();
    pulse_start(4'b0011, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, res_valid, res_bit, res_err} !== 4'b0000 || n_trials !== 16'd0 || n_errors !== 16'd0)
      $display("FAIL async_reset: got %b %0d/%0d want 0000 0/0",
               {busy, res_valid, res_bit, res_err}, n_trials, n_errors);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    m_trials = 0;
    m_errors = 0;
    pulse_start(4'b1100, 1'b1);
    wait_valid(4'b1101, 4'b1100, 1, edges);
    total_cnt++;
    if (edges != SC + 2 || res_bit !== 1'b1 || res_err !== 1'b0)
      $display("FAIL after_reset_result: got lat %0d %b%b want lat %0d 10", edges, res_bit, res_err, SC + 2);
    else pass_cnt++;
    handshake();
    m_trials++;
    total_cnt++;
    if (n_trials !== 16'(m_trials) || n_errors !== 16'd0)
      $display("FAIL after_reset_counters: got %0d/%0d want %0d/0", n_trials, n_errors, m_trials);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int m4t, m4e, edges;
    m4t = 0;
    m4e = 0;
    for (int t = 0; t < 20; t++) begin
      shares    = 4'b0111;
      expected4 = 1'b0;
      start4    = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      edges  = 1;
      while (res_valid4 !== 1'b1 && edges < 50) begin
        @(negedge clk);
        edges++;
      end
      total_cnt++;
      if (edges != SC4 + 2 || res_err4 !== 1'b1)
        $display("FAIL sat_trial: got lat %0d err %b want lat %0d err 1", edges, res_err4, SC4 + 2);
      else pass_cnt++;
      res_ready4 = 1'b1;
      @(negedge clk);
      res_ready4 = 1'b0;
      m4t = (m4t < 15) ? m4t + 1 : 15;
      m4e = (m4e < 15) ? m4e + 1 : 15;
      total_cnt++;
      if (n_trials4 !== 4'(m4t) || n_errors4 !== 4'(m4e))
        $display("FAIL sat_counters: got %0d/%0d want %0d/%0d", n_trials4, n_errors4, m4t, m4e);
      else pass_cnt++;
    end
    clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
    total_cnt++;
    if (n_trials4 !== 4'd0 || n_errors4 !== 4'd0)
      $display("FAIL sat_clr: got %0d/%0d want 0/0", n_trials4, n_errors4);
    else pass_cnt++;
  endtask

  initial begin
    rst        = 1'b1;
    vgnd       = 1'b0;
    vpwr       = 1'b1;
    shares     = 4'b0000;
    start      = 1'b0;
    expected   = 1'b0;
    res_ready  = 1'b0;
    clr        = 1'b0;
    start4     = 1'b0;
    expected4  = 1'b0;
    res_ready4 = 1'b0;
    clr4       = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_stall();
    test_ignore_start();
    test_back_to_back();
    test_clr_handshake();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
